// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one attention core: Q/K load, kernel preload, execute, drain, optional normalize.
// Optional psum row normalization is compiled in with CORE_SEQ_NORM_EN.
module core_seq_ctrl #(
    parameter int COL     = 8,
    parameter int SFP_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  q_len_m1,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fifo_valid,
    output logic [16:0] inst,
    output logic        acc,
    output logic        div,
    output logic        wr_norm,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, LD_Q, LD_K, KLOAD, EXEC, DRAIN, NORM_ACC, NORM_DIV, FINISH
    } state_t;

    localparam logic [4:0] COL_N  = 5'(COL);
    localparam logic [4:0] COL_M1 = 5'(COL - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  qlen_q, qlen_d;
    logic [16:0] inst_q, inst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        in_ready_q, in_ready_d;
    logic [4:0]  qlen_ext;
    logic [3:0]  row_q, row_d;

`ifdef CORE_SEQ_NORM_EN
    localparam logic [4:0] SUB_LAST = 5'(SFP_LAT + 1);
    logic        acc_q, acc_d, div_q, div_d, wr_norm_q, wr_norm_d;
`endif

    assign qlen_ext = {1'b0, qlen_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qlen_d  = qlen_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LD_Q;
                qlen_d  = q_len_m1;
                cnt_d   = '0;
            end
            LD_Q: if (in_valid) begin
                if (cnt_q == qlen_ext) begin
                    state_d = LD_K;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            LD_K: if (in_valid) begin
                if (cnt_q == COL_M1) begin
                    state_d = KLOAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            KLOAD: begin
                if (cnt_q == COL_N) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            EXEC: begin
                if (cnt_q == qlen_ext + 5'd1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            DRAIN: if (fifo_valid) begin
                if (cnt_q == qlen_ext) begin
`ifdef CORE_SEQ_NORM_EN
                    state_d = NORM_ACC;
`else
                    state_d = FINISH;
`endif
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
`ifdef CORE_SEQ_NORM_EN
            NORM_ACC: begin
                if (cnt_q == qlen_ext + 5'd1) begin
                    state_d = NORM_DIV;
                    cnt_d   = '0;
                    row_d   = '0;
                end else cnt_d = cnt_q + 5'd1;
            end
            // cnt is the sub-cycle within the current row, row_q the row itself
            NORM_DIV: begin
                if (cnt_q == SUB_LAST) begin
                    cnt_d = '0;
                    if (row_q == qlen_q) state_d = FINISH;
                    else row_d = row_q + 4'd1;
                end else cnt_d = cnt_q + 5'd1;
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with state_q.
    always_comb begin
        inst_d     = '0;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == LD_Q) || (state_d == LD_K);
`ifdef CORE_SEQ_NORM_EN
        acc_d      = 1'b0;
        div_d      = 1'b0;
        wr_norm_d  = 1'b0;
`endif
        case (state_d)
            KLOAD: begin
                if (cnt_d < COL_N) begin
                    inst_d[3]     = 1'b1;
                    inst_d[15:12] = cnt_d[3:0];
                end
                inst_d[6] = (cnt_d != 5'd0);
            end
            EXEC: begin
                if (cnt_d <= {1'b0, qlen_d}) begin
                    inst_d[5]     = 1'b1;
                    inst_d[15:12] = cnt_d[3:0];
                end
                inst_d[7] = (cnt_d != 5'd0);
            end
`ifdef CORE_SEQ_NORM_EN
            NORM_ACC: begin
                if (cnt_d <= {1'b0, qlen_d}) begin
                    inst_d[1]    = 1'b1;
                    inst_d[11:8] = cnt_d[3:0];
                end
                acc_d = (cnt_d != 5'd0);
            end
            NORM_DIV: begin
                if (cnt_d == 5'd0) begin
                    inst_d[1]    = 1'b1;
                    inst_d[11:8] = row_d;
                end else if (cnt_d == SUB_LAST) begin
                    inst_d[0]    = 1'b1;
                    inst_d[11:8] = row_d;
                    wr_norm_d    = 1'b1;
                end else begin
                    div_d = 1'b1;
                end
            end
`endif
            FINISH:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qlen_q     <= '0;
            row_q      <= '0;
            inst_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qlen_q     <= qlen_d;
            row_q      <= row_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef CORE_SEQ_NORM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= 1'b0;
            div_q     <= 1'b0;
            wr_norm_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            div_q     <= div_d;
            wr_norm_q <= wr_norm_d;
        end
    end
    assign acc     = acc_q;
    assign div     = div_q;
    assign wr_norm = wr_norm_q;
`else
    assign acc     = 1'b0;
    assign div     = 1'b0;
    assign wr_norm = 1'b0;
`endif

    // Load writes and drain pops follow the live handshake inputs; addresses are gated to 0 when idle.
    always_comb begin
        inst = inst_q;
        if (state_q == LD_Q && in_valid) begin
            inst[4]     = 1'b1;
            inst[15:12] = cnt_q[3:0];
        end
        if (state_q == LD_K && in_valid) begin
            inst[2]     = 1'b1;
            inst[15:12] = cnt_q[3:0];
        end
        if (state_q == DRAIN && fifo_valid) begin
            inst[16]    = 1'b1;
            inst[0]     = 1'b1;
            inst[11:8]  = cnt_q[3:0];
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: per-cycle expected outputs are queued with the stimulus and compared as run.
module tb_core_seq_ctrl;

    localparam int COL     = 8;
    localparam int SFP_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  q_len_m1 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        fifo_valid = 1'b0;
    logic [16:0] inst;
    logic        acc, div, wr_norm, busy, done;

    int checks = 0;
    int fails  = 0;

    logic [2:0]  stim_q[$];
    logic [22:0] exp_q[$];

    core_seq_ctrl #(.COL(COL), .SFP_LAT(SFP_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .q_len_m1(q_len_m1),
        .in_valid(in_valid), .in_ready(in_ready), .fifo_valid(fifo_valid),
        .inst(inst), .acc(acc), .div(div), .wr_norm(wr_norm),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [22:0] ev(input logic ir, input logic b, input logic d,
                                       input logic wn, input logic dv, input logic ac,
                                       input logic [16:0] in_w);
        return {ir, b, d, wn, dv, ac, in_w};
    endfunction

    function automatic logic [16:0] qa(input int a);
        return 17'(a) << 12;
    endfunction

    function automatic logic [16:0] pa(input int a);
        return 17'(a) << 8;
    endfunction

    task automatic push(input logic [2:0] s, input logic [22:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected cycle-by-cycle behaviour of a full pass starting from IDLE.
    task automatic gen(input int ql, input logic [15:0] ivp, input int ivn,
                       input logic [15:0] fvp, input int fvn, input bit xs);
        int n, i;
        logic v;
        logic [16:0] w;
        push(3'b100, '0);
        n = 0; i = 0;
        while (n <= ql) begin
            v = (i < ivn) ? ivp[i] : 1'b1;
            w = v ? (17'h00010 | qa(n)) : 17'h0;
            push({1'b0, v, 1'b0}, ev(1, 1, 0, 0, 0, 0, w));
            if (v) n++;
            i++;
        end
        for (int k = 0; k < COL; k++)
            push(3'b010, ev(1, 1, 0, 0, 0, 0, 17'h00004 | qa(k)));
        for (int k = 0; k <= COL; k++) begin
            w = '0;
            if (k < COL) w = 17'h00008 | qa(k);
            if (k >= 1)  w = w | 17'h00040;
            push(3'b000, ev(0, 1, 0, 0, 0, 0, w));
        end
        for (int k = 0; k <= ql + 1; k++) begin
            w = '0;
            if (k <= ql) w = 17'h00020 | qa(k);
            if (k >= 1)  w = w | 17'h00080;
            push({(xs && k == 0), 2'b00}, ev(0, 1, 0, 0, 0, 0, w));
        end
        n = 0; i = 0;
        while (n <= ql) begin
            v = (i < fvn) ? fvp[i] : 1'b1;
            w = v ? (17'h10001 | pa(n)) : 17'h0;
            push({2'b00, v}, ev(0, 1, 0, 0, 0, 0, w));
            if (v) n++;
            i++;
        end
`ifdef CORE_SEQ_NORM_EN
        for (int k = 0; k <= ql + 1; k++) begin
            w = (k <= ql) ? (17'h00002 | pa(k)) : 17'h0;
            push(3'b000, ev(0, 1, 0, 0, 0, (k >= 1), w));
        end
        for (int r = 0; r <= ql; r++) begin
            push(3'b000, ev(0, 1, 0, 0, 0, 0, 17'h00002 | pa(r)));
            for (int s = 1; s <= SFP_LAT; s++)
                push(3'b000, ev(0, 1, 0, 0, 1, 0, 17'h0));
            push(3'b000, ev(0, 1, 0, 1, 0, 0, 17'h00001 | pa(r)));
        end
`endif
        push(3'b000, ev(0, 1, 1, 0, 0, 0, 17'h0));
        push(3'b000, ev(0, 0, 0, 0, 0, 0, 17'h0));
    endtask

    task automatic run(input string tag, input int n);
        int c;
        logic [2:0]  s;
        logic [22:0] e, obs;
        c = 0;
        while (stim_q.size() > 0 && (n < 0 || c < n)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            start = s[2]; in_valid = s[1]; fifo_valid = s[0];
            #1;
            obs = {in_ready, busy, done, wr_norm, div, acc, inst};
            checks++;
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s cyc %0d: got %h expected %h", tag, c, obs, e);
            end
            c++;
        end
    endtask

    task automatic check_idle(input string tag);
        logic [22:0] obs;
        obs = {in_ready, busy, done, wr_norm, div, acc, inst};
        checks++;
        assert (obs === 23'h0) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, 23'h0);
        end
    endtask

    task automatic pass(input string tag, input int ql, input logic [15:0] ivp, input int ivn,
                        input logic [15:0] fvp, input int fvn, input bit xs);
        q_len_m1 = 4'(ql);
        gen(ql, ivp, ivn, fvp, fvn, xs);
        run(tag, -1);
    endtask

    initial begin
        @(negedge clk); #1;
        check_idle("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Load handshake toggling, drain stall, start pulsed while busy.
        pass("ld_drain", 3, 16'b101101, 6, 16'b110011, 6, 1'b1);
        // Longest Q: EXEC spans 17 cycles.
        pass("exec16", 15, 16'h0, 0, 16'h0, 0, 1'b0);
        // Two-row pass; covers normalize when compiled in.
        pass("norm2", 1, 16'h0, 0, 16'b01, 2, 1'b1);

        // Abort during EXEC, then a clean pass.
        q_len_m1 = 4'd3;
        gen(3, 16'h0, 0, 16'h0, 0, 1'b0);
        run("pre_abort", 1 + 4 + COL + (COL + 1) + 3);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; fifo_valid = 1'b0;
        #1;
        check_idle("abort_exec");
        @(negedge clk);
        #1;
        check_idle("abort_hold");
        reset = 1'b1;
        pass("after_abort", 2, 16'h0, 0, 16'b0101, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
